rst_ctrl: RTL and testbench

- Reset-request controller sitting directly downstream of the watchdog timer.
- Consumes the watchdog timeout flag, a software reset command and an external reset request.
- Generates the reset-request pulse that the watchdog/reset sequencer takes as rst_req_i, and a pre-reset interrupt.
- Keeps a sticky, bus-readable reset-cause register and a reset counter. Must sit on the always-on reset (rst_i) so cause survives the reset it requests.

---
 rtl/rst_ctrl_pkg.sv | 27 ++
 rtl/rst_ctrl_regs.sv | 90 +++++++++
 rtl/rst_ctrl.sv | 124 ++++++++++++
 tb/tb_rst_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_ctrl_pkg.sv
// Shared types and constants for the reset-request controller.
// Latency: n/a (package only).
// Backpressure: n/a.
package rst_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRACE   = 2'd1,
        ST_ASSERT  = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_e;

    localparam logic [3:0] ADDR_CTRL  = 4'b1000;
    localparam logic [3:0] ADDR_CAUSE = 4'b1100;

    localparam int CAUSE_WDT = 0;
    localparam int CAUSE_SW  = 1;
    localparam int CAUSE_EXT = 2;
    localparam int CAUSE_W   = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rst_ctrl_regs.sv
// Bus register block: SW_KEY decode, sticky W1C reset cause, saturating reset counter, read mux.
// Latency: reads return rdata_o/rvalid_o one cycle after the request; sw_trig_o is combinational.
// Backpressure: none, zero wait states; every request completes.
// Ports: clk_i/rst_i; bus addr_i/wdata_i/req_i/we_i -> rdata_o/rvalid_o;
//        trigger levels wd_to_i/ext_i, FSM state_i and assert_entry_i in; sw_trig_o out.
module rst_ctrl_regs
    import rst_ctrl_pkg::*;
#(
    parameter int         NBIT   = 32,
    parameter logic [7:0] SW_KEY = 8'hA5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [3:0]      addr_i,
    input  logic [NBIT-1:0] wdata_i,
    input  logic            req_i,
    input  logic            we_i,
    input  logic            wd_to_i,
    input  logic            ext_i,
    input  state_e          state_i,
    input  logic            assert_entry_i,
    output logic            sw_trig_o,
    output logic [NBIT-1:0] rdata_o,
    output logic            rvalid_o
);

    logic                 wr_en;
    logic                 rd_en;
    logic [CAUSE_W-1:0]   cause_q, cause_d;
    logic [CAUSE_W-1:0]   cause_set;
    logic [CAUSE_W-1:0]   cause_clr;
    logic [7:0]           cnt_q, cnt_d;
    logic [NBIT-1:0]      rd_mux;
    logic [NBIT-1:0]      rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;
    logic [NBIT-9:0]      unused_wdata_hi;

    assign unused_wdata_hi = wdata_i[NBIT-1:8];

    assign wr_en = req_i & we_i;
    assign rd_en = req_i & ~we_i;

    // Combinational so the FSM can enter ASSERT on the edge that completes the write.
    assign sw_trig_o = wr_en && (addr_i == ADDR_CTRL) && (wdata_i[7:0] == SW_KEY);

    always_comb begin
        cause_set = '0;
        if (assert_entry_i) begin
            cause_set[CAUSE_WDT] = wd_to_i;
            cause_set[CAUSE_SW]  = sw_trig_o;
            cause_set[CAUSE_EXT] = ext_i;
        end
        cause_clr = (wr_en && (addr_i == ADDR_CAUSE)) ? wdata_i[CAUSE_W-1:0] : '0;
        // A set landing in the same cycle as its W1C survives.
        cause_d = (cause_q & ~cause_clr) | cause_set;
        cnt_d   = (assert_entry_i && (cnt_q != 8'hFF)) ? cnt_q + 8'd1 : cnt_q;
    end

    always_comb begin
        rd_mux = '0;
        case (addr_i)
            ADDR_CTRL: rd_mux[1:0] = state_i;
            ADDR_CAUSE: begin
                rd_mux[15:8]        = cnt_q;
                rd_mux[CAUSE_W-1:0] = cause_q;
            end
            default: rd_mux = '0;
        endcase
        rdata_d  = rd_en ? rd_mux : rdata_q;
        rvalid_d = rd_en;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cause_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            cause_q  <= cause_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;

endmodule

// File: rtl/rst_ctrl.sv
// Reset-request controller: watchdog grace period, fixed-width reset pulse, post-pulse holdoff.
// Latency: trigger to rst_req_o is 1 cycle (sw/ext) or GRACE_CYC cycles after GRACE entry (watchdog).
// Backpressure: none; triggers during ASSERT/HOLDOFF are ignored rather than queued.
// Ports: clk_i/rst_i (always-on reset); bus addr_in/wd_din/wd_req/wd_we -> rdata_o/rvalid_o;
//        wd_to, ext_rst_req_i triggers in; irq_o pre-reset warning and rst_req_o pulse out.
module rst_ctrl
    import rst_ctrl_pkg::*;
#(
    parameter int         NBIT        = 32,
    parameter int         GRACE_CYC   = 1024,
    parameter int         PULSE_CYC   = 16,
    parameter int         HOLDOFF_CYC = 64,
    parameter logic [7:0] SW_KEY      = 8'hA5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [3:0]      addr_in,
    input  logic [NBIT-1:0] wd_din,
    input  logic            wd_req,
    input  logic            wd_we,
    output logic [NBIT-1:0] rdata_o,
    output logic            rvalid_o,
    input  logic            wd_to,
    input  logic            ext_rst_req_i,
    output logic            irq_o,
    output logic            rst_req_o
);

    localparam int TW = $clog2(max3(GRACE_CYC, PULSE_CYC, HOLDOFF_CYC)) + 1;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            irq_q, irq_d;
    logic            sw_trig;
    logic            fast_trig;
    logic            assert_entry;

    assign fast_trig    = sw_trig | ext_rst_req_i;
    assign assert_entry = (state_q != ST_ASSERT) && (state_d == ST_ASSERT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            irq_q   <= irq_d;
        end
    end

    // Timer only counts down while nonzero; each timed state exits when it reads 1.
    always_comb begin
        state_d = state_q;
        irq_d   = irq_q;
        timer_d = (timer_q != '0) ? timer_q - TW'(1) : timer_q;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (fast_trig) begin
                    state_d = ST_ASSERT;
                    timer_d = TW'(PULSE_CYC);
                end else if (wd_to) begin
                    state_d = ST_GRACE;
                    timer_d = TW'(GRACE_CYC);
                    irq_d   = 1'b1;
                end
            end
            ST_GRACE: begin
                if (fast_trig || (wd_to && (timer_q == TW'(1)))) begin
                    state_d = ST_ASSERT;
                    timer_d = TW'(PULSE_CYC);
                end else if (!wd_to) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                    irq_d   = 1'b0;
                end
            end
            ST_ASSERT: begin
                if (timer_q == TW'(1)) begin
                    state_d = ST_HOLDOFF;
                    timer_d = TW'(HOLDOFF_CYC);
                    irq_d   = 1'b0;
                end
            end
            ST_HOLDOFF: begin
                if (timer_q == TW'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
                irq_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        rst_req_o = (state_q == ST_ASSERT);
        irq_o     = irq_q;
    end

    rst_ctrl_regs #(
        .NBIT   (NBIT),
        .SW_KEY (SW_KEY)
    ) u_regs (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .addr_i         (addr_in),
        .wdata_i        (wd_din),
        .req_i          (wd_req),
        .we_i           (wd_we),
        .wd_to_i        (wd_to),
        .ext_i          (ext_rst_req_i),
        .state_i        (state_q),
        .assert_entry_i (assert_entry),
        .sw_trig_o      (sw_trig),
        .rdata_o        (rdata_o),
        .rvalid_o       (rvalid_o)
    );

endmodule

// File: tb/tb_rst_ctrl.sv
// Self-checking bench for rst_ctrl with GRACE_CYC=8, PULSE_CYC=4, HOLDOFF_CYC=6.
// Latency: n/a.
// Backpressure: n/a.
module tb_rst_ctrl;

    localparam int NBIT = 32;
    localparam logic [3:0] A_CTRL  = 4'b1000;
    localparam logic [3:0] A_CAUSE = 4'b1100;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      addr = '0;
    logic [NBIT-1:0] din = '0;
    logic            req = 1'b0;
    logic            we = 1'b0;
    logic            wdt = 1'b0;
    logic            ext = 1'b0;
    logic [NBIT-1:0] rdata;
    logic            rvalid;
    logic            irq;
    logic            rq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rst_ctrl #(
        .NBIT        (NBIT),
        .GRACE_CYC   (8),
        .PULSE_CYC   (4),
        .HOLDOFF_CYC (6),
        .SW_KEY      (8'hA5)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .addr_in       (addr),
        .wd_din        (din),
        .wd_req        (req),
        .wd_we         (we),
        .rdata_o       (rdata),
        .rvalid_o      (rvalid),
        .wd_to         (wdt),
        .ext_rst_req_i (ext),
        .irq_o         (irq),
        .rst_req_o     (rq)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  addr;
        logic [31:0] din;
        logic        req;
        logic        we;
        logic        wdt;
        logic        ext;
        logic        exp_irq;
        logic        exp_rq;
        logic        exp_rv;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[20];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        addr = a;
        din  = d;
        req  = 1'b1;
        we   = 1'b1;
        step();
        req  = 1'b0;
        we   = 1'b0;
        din  = '0;
    endtask

    task automatic bus_rd(input string nm, input logic [3:0] a, input logic [31:0] exp);
        addr = a;
        req  = 1'b1;
        we   = 1'b0;
        step();
        chk({nm, " rvalid"}, {31'b0, rvalid}, 32'd1);
        chk({nm, " rdata"}, rdata, exp);
        req  = 1'b0;
    endtask

    // Called with the first ASSERT cycle already sampled; returns with the DUT back in IDLE.
    task automatic finish_reset(input string nm);
        for (int k = 0; k < 3; k++) begin
            step();
            chk({nm, " pulse"}, {31'b0, rq}, 32'd1);
        end
        step();
        chk({nm, " pulse end"}, {31'b0, rq}, 32'd0);
        repeat (6) step();
    endtask

    initial begin
        logic seen_rq;

        //            rst   addr     din     req   we    wdt   ext   irq   rq    rv    rdata
        tbl[0]  = '{1'b1, 4'h0,   32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 4'h0,   32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 4'h0,   32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, A_CAUSE, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        tbl[4]  = '{1'b0, 4'h0,   32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, A_CTRL, 32'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, A_CTRL, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        tbl[7]  = '{1'b0, A_CTRL, 32'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, A_CTRL, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2};
        tbl[9]  = '{1'b0, A_CAUSE, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h102};
        tbl[10] = '{1'b0, 4'h0,   32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h102};
        tbl[11] = '{1'b0, 4'h0,   32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h102};
        tbl[12] = '{1'b0, 4'h0,   32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h102};
        tbl[13] = '{1'b0, A_CTRL, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3};
        tbl[14] = '{1'b0, 4'h0,   32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3};
        tbl[15] = '{1'b0, 4'h0,   32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3};
        tbl[16] = '{1'b0, 4'h0,   32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3};
        tbl[17] = '{1'b0, 4'h0,   32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3};
        tbl[18] = '{1'b0, A_CAUSE, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h102};
        tbl[19] = '{1'b0, A_CTRL, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};

        // Reset, bad/good SW key, pulse width, holdoff ignoring ext and wd_to.
        for (int i = 0; i < 20; i++) begin
            rst  = tbl[i].rst;
            addr = tbl[i].addr;
            din  = tbl[i].din;
            req  = tbl[i].req;
            we   = tbl[i].we;
            wdt  = tbl[i].wdt;
            ext  = tbl[i].ext;
            step();
            chk($sformatf("vec%0d irq", i), {31'b0, irq}, {31'b0, tbl[i].exp_irq});
            chk($sformatf("vec%0d rst_req", i), {31'b0, rq}, {31'b0, tbl[i].exp_rq});
            chk($sformatf("vec%0d rvalid", i), {31'b0, rvalid}, {31'b0, tbl[i].exp_rv});
            chk($sformatf("vec%0d rdata", i), rdata, tbl[i].exp_rd);
        end
        req = 1'b0;
        we  = 1'b0;

        // W1C clears cause bits, count stays.
        bus_wr(A_CAUSE, 32'h7);
        bus_rd("w1c", A_CAUSE, 32'h100);

        // Watchdog path: irq one cycle after wd_to, pulse exactly GRACE_CYC after GRACE entry.
        wdt = 1'b1;
        step();
        chk("wdt irq T+1", {31'b0, irq}, 32'd1);
        chk("wdt rq T+1", {31'b0, rq}, 32'd0);
        for (int c = 2; c <= 8; c++) begin
            step();
            chk($sformatf("wdt grace T+%0d rq", c), {31'b0, rq}, 32'd0);
            chk($sformatf("wdt grace T+%0d irq", c), {31'b0, irq}, 32'd1);
        end
        for (int c = 9; c <= 12; c++) begin
            step();
            chk($sformatf("wdt pulse T+%0d rq", c), {31'b0, rq}, 32'd1);
            chk($sformatf("wdt pulse T+%0d irq", c), {31'b0, irq}, 32'd1);
        end
        step();
        chk("wdt T+13 rq", {31'b0, rq}, 32'd0);
        chk("wdt T+13 irq", {31'b0, irq}, 32'd0);
        wdt = 1'b0;
        repeat (6) step();
        bus_rd("wdt cause", A_CAUSE, 32'h201);

        // Kick during grace.
        bus_wr(A_CAUSE, 32'h7);
        seen_rq = 1'b0;
        wdt = 1'b1;
        step();
        chk("kick irq set", {31'b0, irq}, 32'd1);
        seen_rq |= rq;
        step();
        seen_rq |= rq;
        step();
        seen_rq |= rq;
        wdt = 1'b0;
        step();
        chk("kick irq clr", {31'b0, irq}, 32'd0);
        for (int k = 0; k < 12; k++) begin
            seen_rq |= rq;
            step();
        end
        seen_rq |= rq;
        chk("kick no rst_req", {31'b0, seen_rq}, 32'd0);
        bus_rd("kick cause", A_CAUSE, 32'h200);

        // Simultaneous ext + wd_to in IDLE: straight to ASSERT, both bits.
        ext = 1'b1;
        wdt = 1'b1;
        step();
        ext = 1'b0;
        wdt = 1'b0;
        chk("simul rq", {31'b0, rq}, 32'd1);
        chk("simul irq", {31'b0, irq}, 32'd0);
        finish_reset("simul");
        bus_rd("simul cause", A_CAUSE, 32'h305);

        // W1C of all bits in the same cycle as an ext-triggered set: ext survives.
        ext = 1'b1;
        bus_wr(A_CAUSE, 32'h7);
        ext = 1'b0;
        chk("setwins rq", {31'b0, rq}, 32'd1);
        finish_reset("setwins");
        bus_rd("setwins cause", A_CAUSE, 32'h404);

        // Counter saturation.
        bus_wr(A_CAUSE, 32'h7);
        for (int n = 0; n < 251; n++) begin
            ext = 1'b1;
            step();
            ext = 1'b0;
            finish_reset("sat");
        end
        bus_rd("cnt 255", A_CAUSE, 32'hFF04);
        for (int n = 0; n < 5; n++) begin
            ext = 1'b1;
            step();
            ext = 1'b0;
            finish_reset("sat2");
        end
        bus_rd("cnt saturated", A_CAUSE, 32'hFF04);

        // Held ext: pulse not extended, retaken one cycle after holdoff ends.
        ext = 1'b1;
        step();
        chk("held A1", {31'b0, rq}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("held pulse", {31'b0, rq}, 32'd1);
        end
        for (int k = 0; k < 7; k++) begin
            step();
            chk($sformatf("held gap%0d", k), {31'b0, rq}, 32'd0);
        end
        step();
        chk("held retrigger", {31'b0, rq}, 32'd1);

        // Mid-operation reset.
        rst = 1'b1;
        step();
        chk("midrst rq", {31'b0, rq}, 32'd0);
        chk("midrst irq", {31'b0, irq}, 32'd0);
        chk("midrst rdata", rdata, 32'h0);
        rst = 1'b0;
        ext = 1'b0;
        bus_rd("midrst cause", A_CAUSE, 32'h0);
        bus_rd("midrst ctrl", A_CTRL, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
